mul_csa_pipe: RTL and testbench

- Pipelined signed/unsigned integer multiplier for the MDU.
- Uses radix-4 Booth partial products and a 3:2 carry-save compression tree, then one final carry-propagate add.
- Takes one operation per cycle through a valid/ready handshake, with fixed 2-cycle latency, backpressure and flush.
- Covers RV64 MUL/MULH/MULHSU/MULHU/MULW in one block, replacing iterative multiply.

---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mul_csa_pipe_csa_tree.sv | 58 +++++
 rtl/mul_csa_pipe.sv | 137 +++++++++++++
 tb/tb_mul_csa_pipe.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: default width, Booth digit
// encoding and partial-product sizing.
package mdu_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [2:0] {
    BOOTH_ZERO,
    BOOTH_P1,
    BOOTH_P2,
    BOOTH_M1,
    BOOTH_M2
  } booth_e;

  // Radix-4 digits needed to cover an operand extended to xlen+2 bits.
  function automatic int pp_count(input int xlen);
    return (xlen + 3) / 2;
  endfunction

  // Overlapping triplet {b[2i+1], b[2i], b[2i-1]} -> signed digit.
  function automatic booth_e booth_encode(input logic [2:0] bits);
    booth_e digit;
    case (bits)
      3'b001, 3'b010: digit = BOOTH_P1;
      3'b011:         digit = BOOTH_P2;
      3'b100:         digit = BOOTH_M2;
      3'b101, 3'b110: digit = BOOTH_M1;
      default:        digit = BOOTH_ZERO;
    endcase
    return digit;
  endfunction

endpackage

// File: rtl/mul_csa_pipe_csa_tree.sv
// Combinational 3:2 carry-save reduction of ROWS addends down to a sum row and
// a carry row; carries are shifted left one place at every level.
module csa_tree #(
  parameter int ROWS = 3,
  parameter int W    = 8
) (
  input  logic [ROWS-1:0][W-1:0] rows,
  output logic [W-1:0]           sum,
  output logic [W-1:0]           carry
);

  function automatic int rows_after(input int n, input int levels);
    int r = n;
    for (int l = 0; l < levels; l++) r = (r / 3) * 2 + r % 3;
    return r;
  endfunction

  function automatic int level_count(input int n);
    int r = n;
    int l = 0;
    while (r > 2) begin
      r = (r / 3) * 2 + r % 3;
      l++;
    end
    return l;
  endfunction

  localparam int LEVELS = level_count(ROWS);

  logic [W-1:0] lv [LEVELS+1][ROWS];

  always_comb begin
    // NOTE: every element gets a default before the reduction so no latch is inferred.
    for (int l = 0; l <= LEVELS; l++)
      for (int r = 0; r < ROWS; r++) lv[l][r] = '0;
    for (int r = 0; r < ROWS; r++) lv[0][r] = rows[r];

    for (int l = 0; l < LEVELS; l++) begin
      for (int g = 0; g < ROWS / 3; g++) begin
        if (g < rows_after(ROWS, l) / 3) begin
          lv[l+1][2*g]   = lv[l][3*g] ^ lv[l][3*g+1] ^ lv[l][3*g+2];
          lv[l+1][2*g+1] = ((lv[l][3*g]   & lv[l][3*g+1]) |
                            (lv[l][3*g]   & lv[l][3*g+2]) |
                            (lv[l][3*g+1] & lv[l][3*g+2])) << 1;
        end
      end
      // Rows left over after grouping by three pass straight down a level.
      for (int k = 0; k < 2; k++) begin
        if (k < rows_after(ROWS, l) % 3)
          lv[l+1][2*(rows_after(ROWS, l)/3)+k] = lv[l][3*(rows_after(ROWS, l)/3)+k];
      end
    end
  end

  assign sum   = lv[LEVELS][0];
  assign carry = lv[LEVELS][1];

endmodule

// File: rtl/mul_csa_pipe.sv
// Two-stage pipelined multiplier: Booth radix-4 partial products and a CSA tree
// in S1, final carry-propagate add and result select in S2.
module mul_csa_pipe
  import mdu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic             a_signed,
  input  logic             b_signed,
  input  logic             hi_sel,
  input  logic             word,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int EXT_W  = XLEN + 2;
  localparam int PROD_W = 2 * XLEN;
  localparam int NPP    = pp_count(XLEN);
  localparam int ROWS   = NPP + 1;

  logic                       word_mode;
  logic                       a_sb, b_sb;
  logic [EXT_W-1:0]           a_ext, b_ext;
  logic [EXT_W:0]             b_pad;
  logic [PROD_W-1:0]          a_wide, a_dbl, mult, corr;
  logic                       neg;
  logic [ROWS-1:0][PROD_W-1:0] pp_rows;
  logic [PROD_W-1:0]          csa_sum, csa_carry;

  logic                       s1_valid, s1_hi, s1_word;
  logic [PROD_W-1:0]          s1_sum, s1_carry;
  logic [TAG_W-1:0]           s1_tag;
  logic [PROD_W-1:0]          product;
  logic [XLEN-1:0]            s2_result;
  logic                       s1_adv, s2_adv;

  assign word_mode = word && (XLEN == 64);

  // Word ops see only the low 32 operand bits, extended per their signed flags.
  always_comb begin
    a_sb  = a_signed & (word_mode ? op_a[31] : op_a[XLEN-1]);
    b_sb  = b_signed & (word_mode ? op_b[31] : op_b[XLEN-1]);
    a_ext = word_mode ? {{(EXT_W-32){a_sb}}, op_a[31:0]} : {{2{a_sb}}, op_a};
    b_ext = word_mode ? {{(EXT_W-32){b_sb}}, op_b[31:0]} : {{2{b_sb}}, op_b};
    a_wide = {{(PROD_W-EXT_W){a_ext[EXT_W-1]}}, a_ext};
    a_dbl  = a_wide << 1;
    b_pad  = {b_ext, 1'b0};
  end

  // Negative digits use one's complement here; the +1 lands in the correction row.
  always_comb begin
    pp_rows = '0;
    corr    = '0;
    mult    = '0;
    neg     = 1'b0;
    for (int i = 0; i < NPP; i++) begin
      mult = '0;
      neg  = 1'b0;
      case (booth_encode(b_pad[2*i +: 3]))
        BOOTH_P1: mult = a_wide;
        BOOTH_P2: mult = a_dbl;
        BOOTH_M1: begin mult = a_wide; neg = 1'b1; end
        BOOTH_M2: begin mult = a_dbl;  neg = 1'b1; end
        default:  mult = '0;
      endcase
      pp_rows[i] = (neg ? ~mult : mult) << (2 * i);
      corr[2*i]  = neg;
    end
    pp_rows[NPP] = corr;
  end

  csa_tree #(
    .ROWS (ROWS),
    .W    (PROD_W)
  ) u_csa (
    .rows  (pp_rows),
    .sum   (csa_sum),
    .carry (csa_carry)
  );

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv && !flush;

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      out_tag   <= '0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (s2_adv) out_valid <= s1_valid;
      if (s2_adv && s1_valid) begin
        result  <= s2_result;
        out_tag <= s1_tag;
      end
    end
  end

  // NOTE: datapath registers carry no reset; their contents only matter once s1_valid is set.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_sum   <= csa_sum;
      s1_carry <= csa_carry;
      s1_hi    <= hi_sel;
      s1_word  <= word_mode;
      s1_tag   <= in_tag;
    end
  end

  assign product = s1_sum + s1_carry;

  always_comb begin
    s2_result = s1_hi ? product[PROD_W-1:XLEN] : product[XLEN-1:0];
    if (s1_word) begin
      s2_result       = {XLEN{product[31]}};
      s2_result[31:0] = product[31:0];
    end
  end

endmodule

// File: tb/tb_mul_csa_pipe.sv
// Scoreboard bench for mul_csa_pipe: directed RV64 cases, backpressure, flush,
// reset, then randomized traffic checked against a plain 128-bit multiply.
module tb_mul_csa_pipe;

  localparam int XLEN  = 64;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush = 1'b0;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  op_a, op_b;
  logic             a_signed, b_signed, hi_sel, word;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] out_tag;

  always #5 clk = ~clk;

  mul_csa_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .a_signed  (a_signed),
    .b_signed  (b_signed),
    .hi_sel    (hi_sel),
    .word      (word),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_tag   (out_tag)
  );

  typedef struct {
    logic [63:0] res;
    logic [3:0]  tag;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   accepted = 0;
  logic or_dir = 1'b1;
  logic fl_dir = 1'b0;
  bit   rand_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: extend both operands to 128 bits and multiply.
  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic as, input logic bs,
                                        input logic hi, input logic wd);
    logic [127:0] ax, bx, p;
    ax = wd ? {{96{as & a[31]}}, a[31:0]} : {{64{as & a[63]}}, a};
    bx = wd ? {{96{bs & b[31]}}, b[31:0]} : {{64{bs & b[63]}}, b};
    p  = ax * bx;
    if (wd) return {{32{p[31]}}, p[31:0]};
    return hi ? p[127:64] : p[63:0];
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(7))
      0:       return 64'h0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      4:       return {32'h0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Stimulus side: present an op, push its expectation when the handshake is seen.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic as,
                       input logic bs, input logic hi, input logic wd,
                       input logic [3:0] tag, input logic [63:0] exp);
    exp_t e;
    op_a = a; op_b = b; a_signed = as; b_signed = bs; hi_sel = hi; word = wd;
    in_tag = tag; in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        e.res = exp; e.tag = tag; e.acc = cyc;
        sb.push_back(e);
        accepted++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    total++; bad++;
    $display("FAIL accept_timeout: tag %0d never accepted", tag);
    in_valid = 1'b0;
  endtask

  task automatic issue_rand(input logic [3:0] tag);
    logic [63:0] a, b;
    logic as, bs, hi, wd;
    a = pick(); b = pick();
    as = 1'($urandom_range(1)); bs = 1'($urandom_range(1));
    hi = 1'($urandom_range(1)); wd = ($urandom_range(3) == 0);
    issue(a, b, as, bs, hi, wd, tag, model(a, b, as, bs, hi, wd));
  endtask

  task automatic drain();
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        @(posedge clk); #1;
        return;
      end
    end
    total++; bad++;
    $display("FAIL drain_timeout: %0d results still outstanding", sb.size());
  endtask

  // Applies out_ready/flush just after each edge: random or directed values.
  initial forever begin
    @(posedge clk); #2;
    if (rand_on) begin
      out_ready = ($urandom_range(3) != 0);
      flush     = ($urandom_range(63) == 0);
    end else begin
      out_ready = or_dir;
      flush     = fl_dir;
    end
  end

  // Monitor: ordering, values, tags, presentation cycle and stall stability.
  bit          prev_stall = 1'b0;
  bit          presented = 1'b0;
  int          last_pop = -100;
  logic [63:0] prev_res;
  logic [3:0]  prev_tag;

  initial forever begin
    exp_t e;
    int   want;
    @(negedge clk);
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
      presented  = 1'b0;
      last_pop   = -100;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_result", result, prev_res);
        check("stall_tag", 64'(out_tag), 64'(prev_tag));
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_output: got tag %0d result %h expected none", out_tag, result);
        end else begin
          if (!presented) begin
            want = sb[0].acc + 2;
            if (last_pop + 1 > want) want = last_pop + 1;
            check("latency", 64'(cyc), 64'(want));
            presented = 1'b1;
          end
          if (out_ready) begin
            e = sb.pop_front();
            check("result", result, e.res);
            check("tag", 64'(out_tag), 64'(e.tag));
            last_pop  = cyc;
            presented = 1'b0;
          end
        end
      end
      if (flush) begin
        sb.delete();
        presented = 1'b0;
        last_pop  = -100;
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_res   = result;
      prev_tag   = out_tag;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0;
    a_signed = 1'b0; b_signed = 1'b0; hi_sel = 1'b0; word = 1'b0; in_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_out_tag", 64'(out_tag), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed RV64 cases with constant expectations.
    issue(64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1, 1, 0, 0, 4'h5, 64'hFFFF_FFFF_FFFF_FFEB);
    drain();
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 0, 4'h1, 64'hFFFF_FFFF_FFFF_FFFE);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 4'h2, 64'h0000_0000_0000_0001);
    issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1, 1, 1, 0, 4'h3, 64'h4000_0000_0000_0000);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1, 0, 1, 0, 4'h4, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(64'hDEAD_BEEF_7FFF_FFFF, 64'd2, 1, 1, 0, 1, 4'h6, 64'hFFFF_FFFF_FFFF_FFFE);
    drain();

    // Backpressure: four ops against a stalled consumer.
    or_dir = 1'b0;
    acc0 = accepted;
    fork
      begin
        for (int k = 0; k < 4; k++) issue_rand(4'(k));
      end
      begin
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_accepted", 64'(accepted - acc0), 64'd2);
        or_dir = 1'b1;
      end
    join
    drain();

    // Flush with two ops in flight; neither may come out.
    or_dir = 1'b0;
    issue(64'd3, 64'd5, 0, 0, 0, 0, 4'h8, 64'd15);
    issue(64'd4, 64'd6, 0, 0, 0, 0, 4'h9, 64'd24);
    fl_dir = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    fl_dir = 1'b0;
    or_dir = 1'b1;
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    issue(64'h0000_0001_0000_0003, 64'h0000_0000_0000_0007, 0, 0, 0, 0, 4'hA, 64'h0000_0007_0000_0015);
    drain();

    // Reset with an op sitting in S1.
    issue(64'd9, 64'd9, 0, 0, 0, 0, 4'hB, 64'd81);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    @(posedge clk); #1;

    // Random traffic with random backpressure and flushes.
    rand_on = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(7) == 0) begin
        @(posedge clk); #1;
      end
      issue_rand(4'(i));
    end
    rand_on = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
